// File: rtl/lock_pkg.sv
// Shared definitions for the keypad entry side and the lock side.
package lock_pkg;

  localparam int unsigned CODE_W = 4;

  typedef logic [CODE_W-1:0] code_t;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSubmit  = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StOpen    = 3'd3;
  localparam logic [2:0] StLockout = 3'd4;

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that times the lockout window; done is high once the window has elapsed.
module lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic done
);

  localparam int unsigned CntW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [CntW-1:0] count_q, count_d;

  // Loading LOCKOUT_CYCLES-1 makes done rise on the last cycle of the window.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = CntW'(LOCKOUT_CYCLES - 1);
    end else if (count_q != '0) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/keypad_code_entry.sv
// Serial keypad code assembly with submit handshake to a lock, retry counting and lockout.
module keypad_code_entry
  import lock_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic              key_bit,
  input  logic              submit,
  input  logic              clear,
  input  logic              unlocked,
  input  logic              wrong_code,
  output logic [CODE_W-1:0] key_input,
  output logic              enter,
  output logic [2:0]        digit_count,
  output logic [2:0]        fail_count,
  output logic              access_granted,
  output logic              locked_out,
  output logic              busy
);

  localparam logic [2:0] FullCount = 3'(CODE_W);

  logic [2:0] state_q, state_d;
  code_t      code_q, code_d;
  logic [2:0] count_q, count_d;
  logic [2:0] fail_q, fail_d;
  logic [2:0] fail_inc;
  logic       enter_q, granted_q, locked_q, busy_q;
  logic       timer_start, timer_done;

  assign fail_inc = fail_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    count_d     = count_q;
    fail_d      = fail_q;
    timer_start = 1'b0;
    case (state_q)
      StIdle: begin
        // Strict strobe priority: a lower strobe is dropped whenever a higher one is present.
        if (clear) begin
          code_d  = '0;
          count_d = '0;
        end else if (submit) begin
          if (count_q == FullCount) begin
            state_d = StSubmit;
          end
        end else if (key_valid && (count_q != FullCount)) begin
          code_d  = {code_q[CODE_W-2:0], key_bit};
          count_d = count_q + 3'd1;
        end
      end
      StSubmit: begin
        state_d = StWait;
      end
      StWait: begin
        code_d  = '0;
        count_d = '0;
        // Both responses asserted is treated as a wrong code.
        if (unlocked && !wrong_code) begin
          state_d = StOpen;
          fail_d  = '0;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == 3'(MAX_TRIES)) begin
            state_d     = StLockout;
            timer_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StOpen: begin
        if (clear) begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (timer_done) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      code_q    <= '0;
      count_q   <= '0;
      fail_q    <= '0;
      enter_q   <= 1'b0;
      granted_q <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      count_q   <= count_d;
      fail_q    <= fail_d;
      enter_q   <= (state_d == StSubmit);
      granted_q <= (state_d == StOpen);
      locked_q  <= (state_d == StLockout);
      busy_q    <= (state_d == StSubmit) || (state_d == StWait) || (state_d == StLockout);
    end
  end

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (timer_start),
    .done   (timer_done)
  );

  assign key_input      = code_q;
  assign enter          = enter_q;
  assign digit_count    = count_q;
  assign fail_count     = fail_q;
  assign access_granted = granted_q;
  assign locked_out     = locked_q;
  assign busy           = busy_q;

endmodule
